// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter: mode encoding and
// the parameter ranges the counter accepts.
package tff_pkg;

  // Operation select carried on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_t;

  // Legal parameter ranges, checked when the counter is elaborated.
  localparam int WIDTH_MIN   = 1;
  localparam int WIDTH_MAX   = 16;
  localparam int MODULUS_MIN = 2;

  // Largest modulus representable in a register of the given width.
  function automatic int max_modulus(input int width);
    return 1 << width;
  endfunction

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// One T flip-flop with a synchronous active-high reset and a
// next-value override used for parallel loads.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ovr,
  input  logic ovr_val,
  output logic q,
  output logic qbar
);

  logic q_q;

  // Reset wins, then the override value, otherwise toggle when t is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (ovr) begin
      q_q <= ovr_val;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// Modulo-MODULUS up/down/toggle counter built from WIDTH T flip-flops.
// Next-state logic picks the target value; each cell toggles where the
// target differs from the current value. Loads go through the cell
// override so the clamped load value lands directly.
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Elaboration-time parameter legality.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("tff_counter: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (MODULUS < MODULUS_MIN || MODULUS > max_modulus(WIDTH)) begin : g_bad_modulus
    $error("tff_counter: MODULUS=%0d outside %0d..2**WIDTH", MODULUS, MODULUS_MIN);
  end

  // Comparisons against MODULUS use one extra bit so MODULUS=2**WIDTH fits.
  localparam int               MOD_INT = MODULUS;
  localparam int               MAX_INT = MODULUS - 1;
  localparam logic [WIDTH:0]   MOD_EXT = MOD_INT[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_INT[WIDTH-1:0];

  mode_t            mode_s;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qbar_w;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] cand_d;
  logic             wrap_d;
  logic             ovf_d;
  logic             wrap_q;
  logic             ovf_q;

  assign mode_s = mode_t'(mode);
  assign cand_d = q_w ^ t_mask;

  // Target value and pulse requests for the coming edge, by priority
  // load > enabled mode > hold (reset is applied inside the registers).
  always_comb begin
    next_d = q_w;
    wrap_d = 1'b0;
    ovf_d  = 1'b0;
    if (load) begin
      if ({1'b0, d} >= MOD_EXT) begin
        next_d = MAX_VAL;
      end else begin
        next_d = d;
      end
    end else if (en) begin
      case (mode_s)
        MODE_UP: begin
          if (q_w == MAX_VAL) begin
            next_d = '0;
            wrap_d = 1'b1;
          end else begin
            next_d = q_w + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (q_w == '0) begin
            next_d = MAX_VAL;
            wrap_d = 1'b1;
          end else begin
            next_d = q_w - 1'b1;
          end
        end
        MODE_TOGGLE: begin
          // Out-of-range toggle results are rejected rather than clamped.
          if ({1'b0, cand_d} < MOD_EXT) begin
            next_d = cand_d;
          end else begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          next_d = q_w;
        end
      endcase
    end
  end

  // A bit toggles exactly where the target differs from the present value.
  assign t_d = q_w ^ next_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .t       (t_d[gi]),
        .ovr     (load),
        .ovr_val (next_d[gi]),
        .q       (q_w[gi]),
        .qbar    (qbar_w[gi])
      );
    end
  endgenerate

  // Registered one-cycle wrap/ovf pulses; the two requests are exclusive
  // because they come from different mode branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = q_w;
  assign qbar = qbar_w;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

  // Terminal count looks at the present value and the operation requested now.
  assign tc = en & ~load &
              (((mode_s == MODE_UP)   && (q_w == MAX_VAL)) ||
               ((mode_s == MODE_DOWN) && (q_w == '0)));

endmodule : tff_counter

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter with WIDTH=4, MODULUS=10.
module tb_tff_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t_mask;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       tc;
  logic       wrap;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  tff_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .t_mask (t_mask),
    .load   (load),
    .d      (d),
    .q      (q),
    .qbar   (qbar),
    .tc     (tc),
    .wrap   (wrap),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Clock one edge, then check q, qbar, range, wrap and ovf against the
  // hand-computed values for that edge.
  task automatic step(input string tag, input logic [3:0] exp_q,
                      input logic exp_wrap, input logic exp_ovf);
    logic [3:0] exp_qbar;
    exp_qbar = ~exp_q;
    @(posedge clk);
    #1;
    $display("[%0t] %s rst=%b load=%b d=%h en=%b mode=%b mask=%h -> q=%h qbar=%h wrap=%b ovf=%b",
             $time, tag, rst, load, d, en, mode, t_mask, q, qbar, wrap, ovf);
    check({tag, ".q"},     {28'd0, q},    {28'd0, exp_q});
    check({tag, ".qbar"},  {28'd0, qbar}, {28'd0, exp_qbar});
    check({tag, ".range"}, {31'd0, (q < 4'd10)}, 32'd1);
    check({tag, ".wrap"},  {31'd0, wrap}, {31'd0, exp_wrap});
    check({tag, ".ovf"},   {31'd0, ovf},  {31'd0, exp_ovf});
  endtask

  // tc is combinational; sample after the inputs have settled.
  task automatic check_tc(input string tag, input logic exp_tc);
    #1;
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, exp_tc});
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] dv,
                       input logic e, input logic [1:0] m, input logic [3:0] tm);
    rst = r; load = l; d = dv; en = e; mode = m; t_mask = tm;
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'h7, 1'b0, 2'b00, 4'h0);

    // Reset overrides a pending load.
    step("rst0", 4'h0, 1'b0, 1'b0);
    step("rst1", 4'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'b10, 4'h0);
    check_tc("tc_disabled_q0", 1'b0);

    // Up count through the wrap.
    drive(1'b0, 1'b1, 4'h8, 1'b0, 2'b00, 4'h0);
    step("load8", 4'h8, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 2'b01, 4'h0);
    check_tc("tc_up_q8", 1'b0);
    step("up9", 4'h9, 1'b0, 1'b0);
    check_tc("tc_up_q9", 1'b1);
    step("up0", 4'h0, 1'b1, 1'b0);
    check_tc("tc_up_q0", 1'b0);
    step("up1", 4'h1, 1'b0, 1'b0);

    // Down count through the wrap.
    drive(1'b0, 1'b0, 4'h0, 1'b1, 2'b10, 4'h0);
    check_tc("tc_dn_q1", 1'b0);
    step("dn0", 4'h0, 1'b0, 1'b0);
    check_tc("tc_dn_q0", 1'b1);
    step("dn9", 4'h9, 1'b1, 1'b0);
    check_tc("tc_dn_q9", 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'b10, 4'h0);
    step("hold_en0", 4'h9, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'h0);
    step("hold_m00", 4'h9, 1'b0, 1'b0);

    // Toggle mask: accepted result, then a rejected out-of-range result.
    drive(1'b0, 1'b1, 4'h5, 1'b0, 2'b00, 4'h0);
    step("load5", 4'h5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 2'b11, 4'h3);
    check_tc("tc_toggle", 1'b0);
    step("tog6", 4'h6, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 2'b11, 4'hC);
    step("tog_rej", 4'h6, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 2'b11, 4'hC);
    step("tog_idle", 4'h6, 1'b0, 1'b0);

    // Load clamp beats an enabled count.
    drive(1'b0, 1'b1, 4'hF, 1'b1, 2'b01, 4'h0);
    step("clamp", 4'h9, 1'b0, 1'b0);
    check_tc("tc_load_q9", 1'b0);
    // Load at the wrap point must not pulse wrap.
    step("clamp2", 4'h9, 1'b0, 1'b0);

    // Reset beats load mid-count, then counting resumes from zero.
    drive(1'b1, 1'b1, 4'h3, 1'b1, 2'b01, 4'h0);
    step("rst_ld", 4'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 2'b01, 4'h0);
    step("post_rst", 4'h1, 1'b0, 1'b0);
    step("post_rst2", 4'h2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tff_counter

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter/register width in bits, legal range 1..16.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  count/toggle enable.
REQ-006 mode  input  2  operation select: 00 hold, 01 count up, 10 count down, 11 toggle-mask.
REQ-007 t_mask  input  WIDTH  per-bit T inputs, used only in mode 11.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 d  input  WIDTH  parallel load value.
REQ-010 q  output  WIDTH  registered count/state.
REQ-011 qbar  output  WIDTH  bitwise complement of q, always equal to ~q.
REQ-012 tc  output  1  combinational terminal count.
REQ-013 wrap  output  1  registered one-cycle pulse marking a wrap.
REQ-014 ovf  output  1  registered one-cycle pulse marking a rejected toggle result.

Function
REQ-015 Priority at each rising clk edge SHALL be rst > load > (en and mode) > hold.
REQ-016 load=1: q SHALL take d next cycle; if d >= MODULUS, q SHALL take MODULUS-1; wrap and ovf SHALL be 0.
REQ-017 en=0 or mode=00 (no load): q SHALL hold; wrap and ovf SHALL be 0 next cycle.
REQ-018 Mode 01: q SHALL increment by 1; at q=MODULUS-1 it SHALL become 0 and wrap SHALL be 1 next cycle.
REQ-019 Mode 10: q SHALL decrement by 1; at q=0 it SHALL become MODULUS-1 and wrap SHALL be 1 next cycle.
REQ-020 Mode 11: candidate = q XOR t_mask (each bit a T flip-flop); if candidate < MODULUS, q SHALL take it; otherwise q SHALL hold and ovf SHALL be 1 next cycle.
REQ-021 tc SHALL be 1 only when en=1, load=0 and either mode=01 with q=MODULUS-1 or mode=10 with q=0; otherwise 0.
REQ-022 wrap and ovf SHALL each be high for exactly one cycle per causing edge and SHALL never be high together.
REQ-023 q SHALL never hold a value >= MODULUS outside reset.
REQ-024 Latency: every q change SHALL be visible one cycle after the causing edge, with no combinational path from inputs to q.
REQ-025 When MODULUS = 2**WIDTH, wrap arithmetic SHALL be plain modulo-2**WIDTH, with identical behaviour.

Reset
REQ-026 rst=1 at a rising edge SHALL set q=0, qbar=all ones, wrap=0 and ovf=0, overriding load and en.
REQ-027 rst asserted mid-count SHALL abort the operation; the first edge after rst deasserts SHALL operate from q=0.
REQ-028 tc SHALL be 0 while q=0 and mode!=10; no output SHALL be X after the first reset edge.

Structure
REQ-029 Package tff_pkg SHALL hold the mode encoding constants (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_TOGGLE) and the 2-bit mode type.
REQ-030 Sub-module tff_cell SHALL implement one T flip-flop (clk, rst, t, next-value override, q, qbar) with synchronous active-high reset.
REQ-031 The counter SHALL be WIDTH tff_cell instances plus next-state logic that computes per-bit T = q XOR next.
REQ-032 Parameter legality SHALL be checked at elaboration, with an error on an illegal value.

Verification (WIDTH=4, MODULUS=10)
REQ-033 Reset: rst=1 for 2 cycles with load=1, d=7 -> q=0, qbar=1111, wrap=0, ovf=0.
REQ-034 Up wrap: load d=8, then en=1, mode=01 for 3 cycles -> q 9,0,1; tc=1 while q=9; wrap pulses once when q becomes 0.
REQ-035 Down wrap: q=1, en=1, mode=10 for 2 cycles -> q 0,9; tc=1 while q=0; wrap pulses once.
REQ-036 Toggle: q=0101, mode=11, t_mask=0011 -> q=0110; next t_mask=1100 -> candidate 1010 (10) is rejected, so q stays 0110 and ovf pulses once.
REQ-037 Clamp and priority: load=1, d=1111 with en=1, mode=01 -> q=9; then rst=1 together with load=1 -> q=0.
REQ-038 Every cycle of every scenario -> qbar equals ~q and q < 10.
